// File: rtl/dp_pipe_reg_pkg.sv
// Shared datapath helpers for the pipeline register slice.
// The occupancy counter width comes from here so every user sizes it the same way.
package dp_pipe_reg_pkg;

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dp_pipe_reg_if.sv
// Valid/ready word channel between datapath units.
// The master drives valid and data, and the slave drives ready.
interface dp_pipe_reg_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dp_pipe_stage.sv
// One pipeline slot: a valid flop plus a non-reset data flop, loading whenever the slot is empty or its consumer takes.
// The cycle latency is 1. The ready signal is combinational, !valid | dn_ready, so a full stage stalls only when downstream stalls.
module dp_pipe_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign ready = !valid | dn_ready;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
        end
    end

    // Data is left unreset and loads only with a real word, so bubbles never disturb held data.
    always_ff @(posedge clk) begin
        if (ready && up_valid) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/dp_pipe_reg.sv
// DEPTH-stage valid/ready pipeline register with bubble collapsing, synchronous flush and an occupancy count.
// The latency is DEPTH cycles when unstalled. in_ready is a combinational chain from dn.ready and is low during flush.
module dp_pipe_reg
    import dp_pipe_reg_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                flush,
    dp_pipe_reg_if.slave        up,
    dp_pipe_reg_if.master       dn,
    output logic [CW-1:0]       occupancy
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dp_pipe_reg: DEPTH must be at least 1");
    end

    // Each stage gets its own signals, so the ready chain is a set of distinct nets rather than one self-referencing vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             vld;
        logic             rdy;
        logic             nxt_rdy;
        logic             in_vld;
        logic [WIDTH-1:0] in_dat;
        logic [WIDTH-1:0] dat;

        if (k == DEPTH - 1) begin : g_last
            assign nxt_rdy = dn.ready;
        end else begin : g_mid
            assign nxt_rdy = g_stage[k+1].rdy;
        end

        if (k == 0) begin : g_first
            assign in_vld = up.valid & !flush;
            assign in_dat = up.data;
        end else begin : g_chain
            assign in_vld = g_stage[k-1].vld;
            assign in_dat = g_stage[k-1].dat;
        end

        dp_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .reset_l  (reset_l),
            .flush    (flush),
            .up_valid (in_vld),
            .up_data  (in_dat),
            .dn_ready (nxt_rdy),
            .ready    (rdy),
            .valid    (vld),
            .data     (dat)
        );
    end

    assign up.ready = g_stage[0].rdy & !flush;
    assign dn.valid = g_stage[DEPTH-1].vld;
    assign dn.data  = g_stage[DEPTH-1].dat;

    logic push;
    logic pop;

    assign push = up.valid & up.ready;
    assign pop  = dn.valid & dn.ready;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (push && !pop) begin
            occupancy <= occupancy + CW'(1);
        end else if (pop && !push) begin
            occupancy <= occupancy - CW'(1);
        end
    end

endmodule

// File: tb/tb_dp_pipe_reg.sv
// Bench for dp_pipe_reg. It drives DEPTH=2, 3 and 4 instances from shared stimulus and checks the selected one against a word/position queue model.
module tb_dp_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    dp_pipe_reg_if #(.WIDTH(16)) in2 ();
    dp_pipe_reg_if #(.WIDTH(16)) out2 ();
    dp_pipe_reg_if #(.WIDTH(16)) in3 ();
    dp_pipe_reg_if #(.WIDTH(16)) out3 ();
    dp_pipe_reg_if #(.WIDTH(16)) in4 ();
    dp_pipe_reg_if #(.WIDTH(16)) out4 ();

    assign in2.valid = in_valid;  assign in2.data = in_data;  assign out2.ready = out_ready;
    assign in3.valid = in_valid;  assign in3.data = in_data;  assign out3.ready = out_ready;
    assign in4.valid = in_valid;  assign in4.data = in_data;  assign out4.ready = out_ready;

    logic [1:0] occ2;
    logic [1:0] occ3;
    logic [2:0] occ4;

    dp_pipe_reg #(.WIDTH(16), .DEPTH(2)) u_d2 (
        .clk(clk), .reset_l(rst_n), .flush(flush), .up(in2), .dn(out2), .occupancy(occ2));
    dp_pipe_reg #(.WIDTH(16), .DEPTH(3)) u_d3 (
        .clk(clk), .reset_l(rst_n), .flush(flush), .up(in3), .dn(out3), .occupancy(occ3));
    dp_pipe_reg #(.WIDTH(16), .DEPTH(4)) u_d4 (
        .clk(clk), .reset_l(rst_n), .flush(flush), .up(in4), .dn(out4), .occupancy(occ4));

    int          sel = 0;
    logic        o_in_ready;
    logic        o_out_valid;
    logic [15:0] o_out_data;
    int          o_occ;

    always_comb begin
        o_in_ready  = in2.ready;
        o_out_valid = out2.valid;
        o_out_data  = out2.data;
        o_occ       = int'(occ2);
        case (sel)
            1: begin
                o_in_ready = in3.ready; o_out_valid = out3.valid; o_out_data = out3.data; o_occ = int'(occ3);
            end
            2: begin
                o_in_ready = in4.ready; o_out_valid = out4.valid; o_out_data = out4.data; o_occ = int'(occ4);
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    // The reference model keeps the held words oldest-first, each with its stage index.
    int          mdepth = 2;
    logic [15:0] mq_d[$];
    int          mq_p[$];
    logic [15:0] out_log[$];

    logic        exp_in_ready, exp_out_valid;
    logic [15:0] exp_out_data;
    int          exp_occ;
    logic        act_in_ready, act_out_valid;
    logic [15:0] act_out_data;
    int          act_occ;

    function automatic void model_expect();
        int n;
        n             = mq_d.size();
        exp_in_ready  = !flush && (n < mdepth || out_ready);
        exp_out_valid = (n > 0) && (mq_p[0] == mdepth - 1);
        exp_out_data  = (n > 0) ? mq_d[0] : 16'h0;
        exp_occ       = n;
    endfunction

    task automatic model_clock();
        logic pop, push;
        pop  = exp_out_valid && out_ready;
        push = in_valid && exp_in_ready;
        // A word advances if the consumer takes, or if one of the slots ahead of it is free (i words ahead of it are older).
        for (int i = 0; i < mq_p.size(); i++) begin
            if (mq_p[i] < mdepth - 1 && (out_ready || i < mdepth - 1 - mq_p[i]))
                mq_p[i] = mq_p[i] + 1;
        end
        if (pop) begin
            void'(mq_d.pop_front());
            void'(mq_p.pop_front());
        end
        if (flush) begin
            mq_d.delete();
            mq_p.delete();
        end else if (push) begin
            mq_d.push_back(in_data);
            mq_p.push_back(0);
        end
    endtask

    // Inputs are set at a falling edge. Outputs are sampled 2 time units later, and the task returns at the next falling edge.
    task automatic tick();
        #2;
        model_expect();
        act_in_ready  = o_in_ready;
        act_out_valid = o_out_valid;
        act_out_data  = o_out_data;
        act_occ       = o_occ;
        if (act_out_valid && out_ready) out_log.push_back(act_out_data);
        model_clock();
        @(negedge clk);
    endtask

    task automatic reset_all(input int s);
        sel = s;
        mdepth = (s == 0) ? 2 : ((s == 1) ? 3 : 4);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq_d.delete(); mq_p.delete(); out_log.delete();
    endtask

    task automatic test_reset();
        reset_all(0);
        tick();
        n_checks++; if (act_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", act_out_valid); end
        n_checks++; if (act_occ != 0) begin n_errors++; $display("FAIL reset_occupancy: got %0d expected 0", act_occ); end
        n_checks++; if (act_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0b expected 1", act_in_ready); end
        in_valid = 1'b1; in_data = 16'h1111; tick();
        in_data = 16'h2222; tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (o_occ != 2) begin n_errors++; $display("FAIL pre_reset_occupancy: got %0d expected 2", o_occ); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL async_reset_out_valid: got %0b expected 0", o_out_valid); end
        n_checks++; if (o_occ != 0) begin n_errors++; $display("FAIL async_reset_occupancy: got %0d expected 0", o_occ); end
        @(negedge clk);
        mq_d.delete(); mq_p.delete(); out_log.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (act_out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_stale_word: cycle %0d got out_valid %0b expected 0", c, act_out_valid); end
        end
        in_valid = 1'b1; in_data = 16'h3333; tick();
        in_valid = 1'b0; tick(); tick();
        n_checks++;
        if (out_log.size() != 1 || out_log[0] !== 16'h3333) begin
            n_errors++; $display("FAIL post_reset_first_word: got %0d words first %0h expected 1 word 3333",
                                 out_log.size(), (out_log.size() > 0) ? out_log[0] : 16'h0);
        end
    endtask

    task automatic test_streaming();
        int first, last;
        reset_all(1);
        out_ready = 1'b1;
        first = -1; last = -1;
        for (int c = 0; c < 22; c++) begin
            in_valid = (c < 16);
            in_data  = 16'(c + 1);
            tick();
            if (c < 16) begin
                n_checks++; if (act_in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready: cycle %0d got %0b expected 1", c, act_in_ready); end
            end
            if (act_out_valid) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        n_checks++; if (first != 3) begin n_errors++; $display("FAIL stream_latency: first out_valid cycle %0d expected 3", first); end
        n_checks++; if (last - first != 15) begin n_errors++; $display("FAIL stream_contiguous: span %0d expected 15", last - first); end
        n_checks++; if (out_log.size() != 16) begin n_errors++; $display("FAIL stream_count: got %0d expected 16", out_log.size()); end
        for (int i = 0; i < out_log.size(); i++) begin
            n_checks++; if (out_log[i] !== 16'(i + 1)) begin n_errors++; $display("FAIL stream_order: word %0d got %0h expected %0h", i, out_log[i], i + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] words [3];
        int w;
        words[0] = 16'hA5A5; words[1] = 16'h5A5A; words[2] = 16'hFFFF;
        reset_all(0);
        w = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_data = words[w];
            tick();
            if (act_in_ready) w++;
            if (c < 2) begin
                n_checks++; if (act_in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_accept: cycle %0d got %0b expected 1", c, act_in_ready); end
            end else begin
                n_checks++; if (act_in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready: cycle %0d got %0b expected 0", c, act_in_ready); end
                n_checks++; if (act_occ != 2) begin n_errors++; $display("FAIL bp_occupancy: cycle %0d got %0d expected 2", c, act_occ); end
                n_checks++; if (act_out_valid !== 1'b1 || act_out_data !== 16'hA5A5) begin
                    n_errors++; $display("FAIL bp_hold: cycle %0d got v=%0b d=%0h expected v=1 d=a5a5", c, act_out_valid, act_out_data); end
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (act_in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %0b expected 1", act_in_ready); end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_checks++;
        if (out_log.size() != 3 || out_log[0] !== 16'hA5A5 || out_log[1] !== 16'h5A5A || out_log[2] !== 16'hFFFF) begin
            n_errors++; $display("FAIL bp_order: got %0d words %p expected a5a5 5a5a ffff", out_log.size(), out_log);
        end
    endtask

    task automatic test_full_passthrough();
        reset_all(0);
        in_valid = 1'b1;
        in_data = 16'h0101; tick();
        in_data = 16'h0202; tick();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = 16'h0303 + 16'(c * 16'h0101);
            tick();
            n_checks++; if (act_in_ready !== 1'b1) begin n_errors++; $display("FAIL pass_in_ready: cycle %0d got %0b expected 1", c, act_in_ready); end
            n_checks++; if (act_occ != 2) begin n_errors++; $display("FAIL pass_occupancy: cycle %0d got %0d expected 2", c, act_occ); end
            n_checks++; if (act_out_valid !== 1'b1) begin n_errors++; $display("FAIL pass_bubble: cycle %0d got out_valid %0b expected 1", c, act_out_valid); end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        n_checks++; if (out_log.size() != 6) begin n_errors++; $display("FAIL pass_count: got %0d expected 6", out_log.size()); end
        for (int i = 0; i < out_log.size(); i++) begin
            n_checks++; if (out_log[i] !== 16'h0101 * 16'(i + 1)) begin
                n_errors++; $display("FAIL pass_order: word %0d got %0h expected %0h", i, out_log[i], 16'h0101 * 16'(i + 1)); end
        end
    endtask

    task automatic test_flush();
        reset_all(0);
        in_valid = 1'b1;
        in_data = 16'h1234; tick();
        in_data = 16'h5678; tick();
        flush = 1'b1; in_data = 16'hDEAD;
        tick();
        n_checks++; if (act_in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %0b expected 0", act_in_ready); end
        n_checks++; if (act_occ != 2) begin n_errors++; $display("FAIL flush_pre_occupancy: got %0d expected 2", act_occ); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++; if (act_out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_out_valid: got %0b expected 0", act_out_valid); end
        n_checks++; if (act_occ != 0) begin n_errors++; $display("FAIL flush_occupancy: got %0d expected 0", act_occ); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        n_checks++; if (out_log.size() != 0) begin n_errors++; $display("FAIL flush_leak: got %0d words expected 0", out_log.size()); end
    endtask

    task automatic test_bubble_collapse();
        reset_all(2);
        for (int c = 0; c < 8; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 16'hB001 + 16'(c / 2);
            tick();
            if (in_valid) begin
                n_checks++; if (act_in_ready !== 1'b1) begin n_errors++; $display("FAIL bubble_accept: cycle %0d got %0b expected 1", c, act_in_ready); end
            end
        end
        in_valid = 1'b1; in_data = 16'hBBBB;
        tick();
        n_checks++; if (act_occ != 4) begin n_errors++; $display("FAIL bubble_occupancy: got %0d expected 4", act_occ); end
        n_checks++; if (act_in_ready !== 1'b0) begin n_errors++; $display("FAIL bubble_full: got in_ready %0b expected 0", act_in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        n_checks++;
        if (out_log.size() != 4 || out_log[0] !== 16'hB001 || out_log[1] !== 16'hB002 ||
            out_log[2] !== 16'hB003 || out_log[3] !== 16'hB004) begin
            n_errors++; $display("FAIL bubble_order: got %0d words %p expected b001..b004", out_log.size(), out_log);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            reset_all(s);
            for (int c = 0; c < 400; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                flush     = ($urandom_range(0, 19) == 0);
                in_data   = 16'($urandom);
                tick();
                n_checks++; if (act_in_ready !== exp_in_ready) begin n_errors++; $display("FAIL rand_in_ready: depth %0d cycle %0d got %0b expected %0b", mdepth, c, act_in_ready, exp_in_ready); end
                n_checks++; if (act_out_valid !== exp_out_valid) begin n_errors++; $display("FAIL rand_out_valid: depth %0d cycle %0d got %0b expected %0b", mdepth, c, act_out_valid, exp_out_valid); end
                n_checks++; if (act_occ != exp_occ) begin n_errors++; $display("FAIL rand_occupancy: depth %0d cycle %0d got %0d expected %0d", mdepth, c, act_occ, exp_occ); end
                if (exp_out_valid) begin
                    n_checks++; if (act_out_data !== exp_out_data) begin n_errors++; $display("FAIL rand_out_data: depth %0d cycle %0d got %0h expected %0h", mdepth, c, act_out_data, exp_out_data); end
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_passthrough();
        test_flush();
        test_bubble_collapse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dp_pipe_reg.md
Name: dp_pipe_reg

Overview:
- Parametrised datapath pipeline register, generalising the fixed 16-bit single-stage register.
- WIDTH bits, DEPTH stages, per-stage valid bits, valid/ready flow control, bubble collapsing, synchronous flush and an occupancy count.
- Sits between datapath units (e.g. vector unit operand/result paths) where a downstream unit can stall.
- Throughput is one word per clock when not stalled.

Parameters:
- WIDTH, 16, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1); DEPTH=0 is illegal and must fail elaboration.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not user-set).

Ports:
- clk  input  1  rising-edge clock.
- reset_l  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all held words.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  word present at last stage.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  last-stage data.
- occupancy  output  CW  number of valid stages.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_l.
- Per-stage state is v[k] and d[k], for k = 0..DEPTH-1; stage 0 is the input, stage DEPTH-1 is the output.
- Reset (reset_l=0, asynchronous): all v[k]=0 and occupancy=0, so out_valid=0. d[k] are not reset; out_data is don't-care while out_valid=0.
- Ready chain: r[DEPTH]=out_ready; r[k] = !v[k] | r[k+1]; in_ready = r[0] & !flush.
  - in_ready is combinational through the chain. This is an accepted timing path and is documented for synthesis.
- Stage advance: stage k loads when r[k]=1.
  - v[k] <= (k==0 ? in_valid & !flush : v[k-1]).
  - d[k] <= upstream data, but only if the incoming valid is 1; otherwise d[k] holds.
- Hold: when v[k]=1 and r[k]=0, d[k] and v[k] are stable. out_data must not change while out_valid=1 and out_ready=0.
- Latency: an accepted word appears on out_valid DEPTH cycles later if no stall. A bubble collapses only when a downstream stage is full and stalled.
- Throughput: with out_ready=1 continuously, one word per cycle; in_ready stays 1.
- Full: all v=1 and out_ready=0 gives in_ready=0. out_ready=1 in the same cycle gives in_ready=1 (pass-through, no cycle lost).
- Empty: out_valid=0; out_ready is ignored.
- Flush (synchronous, priority over all):
  - Next cycle all v=0 and occupancy=0.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - An out_valid & out_ready handshake in the flush cycle still counts as delivered.
- Occupancy: register.
  - +1 on (in_valid & in_ready).
  - -1 on (out_valid & out_ready).
  - Unchanged if both occur.
  - 0 on flush.
  - Never exceeds DEPTH and never underflows; the bench asserts occupancy == popcount(v).
- Reset mid-transfer: all words are lost, and the first post-reset out_valid comes only from new input.
- DEPTH=1 degenerates to a single register with ready pass-through (in_ready = !v[0] | out_ready).

Decomposition:
- No shared package types needed. The occupancy-width helper (clog2) goes in the existing datapath utility include as a function, not local to this module.
- One sub-module: dp_pipe_stage, with WIDTH parameter and ports clk, reset_l, flush, up_valid, up_data, dn_ready, ready, valid, data.
  - It is instantiated DEPTH times via generate.
  - Its storage uses the standard non-reset flop cell for data and a reset flop for valid.

Test Plan:
- Reset: hold reset_l=0 mid-stream with DEPTH=2 → out_valid=0 and occupancy=0 immediately, asynchronously, without waiting for a clk edge.
- Streaming: WIDTH=16, DEPTH=3, push 0x0001..0x0010 back-to-back with out_ready=1 → first out_valid at cycle 3, then 16 consecutive words in order, and in_ready never drops.
- Backpressure: DEPTH=2, out_ready=0, push 0xA5A5, 0x5A5A, 0xFFFF → first two accepted, then in_ready=0 and occupancy=2, with out_data held at 0xA5A5. Release out_ready → order is 0xA5A5, 0x5A5A, 0xFFFF.
- Full pass-through: full pipe, out_ready=1 and in_valid=1 in the same cycle → in_ready=1, occupancy stays 2, no bubble.
- Flush: occupancy=2, assert flush with in_valid=1 for 1 cycle → in_ready=0 that cycle, next cycle out_valid=0 and occupancy=0, and the flushed input word never appears.
- Bubble collapse: DEPTH=4, alternate in_valid 1/0 with out_ready held 0 → four words fill all stages (occupancy=4), and output order is preserved after release.
